// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// synchronises and debounces the rows, and reports one hex key code per press.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DB_DONE   = DW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      row_m_q, row_s_q;
    logic [TW-1:0]   tick_q;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      col_q, col_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [3:0]      lrow_q, lrow_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            held_q, held_d;
    logic            sample;
    logic            adv;

    // True when exactly one row line is pulled low.
    function automatic logic one_low(input logic [3:0] r);
        logic [3:0] a;
        a = ~r;
        return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
    endfunction

    // Index of the single low row (only meaningful when one_low is true).
    function automatic logic [1:0] row_index(input logic [3:0] r);
        case (r)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Physical keypad layout: {row, col} -> hex code.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'h0;  4'hD: return 4'hF;  4'hE: return 4'hE;  default: return 4'hD;
        endcase
    endfunction

    // Active-low one-hot column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] i);
        return ~(4'b0001 << i);
    endfunction

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m_q <= 4'hF;
            row_s_q <= 4'hF;
        end else begin
            row_m_q <= row;
            row_s_q <= row_m_q;
        end
    end

    // Column dwell counter; its last tick is the only point rows are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else if (tick_q == TICK_LAST) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + TW'(1);
        end
    end

    assign sample = (tick_q == TICK_LAST);

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            idx_q   <= 2'd0;
            col_q   <= 4'b1110;
            cnt_q   <= '0;
            lrow_q  <= 4'hF;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            lrow_q  <= lrow_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    // Next-state logic: scan, debounce the press, then debounce the release.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        lrow_d  = lrow_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        adv     = 1'b0;

        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (one_low(row_s_q)) begin
                        lrow_d  = row_s_q;
                        cnt_d   = DW'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        // Idle or ghost/multi-press: keep scanning.
                        adv = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (row_s_q == lrow_q) begin
                        if (cnt_q + DW'(1) == DB_DONE) begin
                            code_d  = key_map(row_index(lrow_q), idx_q);
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = PRESSED;
                        end else begin
                            cnt_d = cnt_q + DW'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        adv     = 1'b1;
                        state_d = SCAN;
                    end
                end
                PRESSED: begin
                    if (row_s_q == 4'hF) begin
                        if (cnt_q + DW'(1) == DB_DONE) begin
                            held_d  = 1'b0;
                            cnt_d   = '0;
                            adv     = 1'b1;
                            state_d = SCAN;
                        end else begin
                            cnt_d = cnt_q + DW'(1);
                        end
                    end else begin
                        // Bounce or extra key while held: restart release count.
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            endcase
        end

        if (adv) begin
            idx_d = idx_q + 2'd1;
            col_d = col_drive(idx_d);
        end
    end

    assign col       = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scenarios against a keypad matrix model, with a
// scoreboard of expected key codes consumed on every key_valid pulse.
module tb_keypad_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;      // keys[r*4+c] = 1 when key (r,c) is pressed
    logic        ghost;     // forces two rows low on columns 0 and 1
    int          total;
    int          bad;
    int          valid_cnt;
    logic        prev_valid;
    logic [3:0]  exp_q[$];

    keypad_scanner #(
        .SCAN_TICKS(8),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model: a pressed key pulls its row low when its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
        if (ghost && (col == 4'b1110 || col == 4'b1101)) row = 4'b1001;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every key_valid pops one expected code.
    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            valid_cnt++;
            check("valid_single_cycle", int'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", exp_q.size(), 1);
            end else begin
                check("key_code_at_valid", int'(key_code), int'(exp_q.pop_front()));
                check("held_at_valid", int'(key_held), 1);
            end
        end
        prev_valid = rst_n ? key_valid : 1'b0;
    end

    task automatic wait_valid(input string tag, input int budget);
        int start;
        int n;
        start = valid_cnt;
        n = 0;
        while (valid_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, valid_cnt - start, 1);
    endtask

    task automatic wait_held_low(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (key_held && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check(tag, int'(key_held), 0);
    endtask

    task automatic wait_col(input string tag, input logic [3:0] c, input int budget);
        int n;
        n = 0;
        while (col !== c && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(col), int'(c));
    endtask

    initial begin
        int cyc;
        int base;
        total      = 0;
        bad        = 0;
        valid_cnt  = 0;
        prev_valid = 1'b0;
        keys       = '0;
        ghost      = 1'b0;
        rst_n      = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_col", int'(col), 'hE);
        check("rst_code", int'(key_code), 0);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        rst_n = 1'b1;

        // Idle scan: column changes on the 8th edge after reset release.
        repeat (7) @(negedge clk);
        check("idle_col0_hold", int'(col), 'hE);
        @(negedge clk);
        check("idle_col1", int'(col), 'hD);
        repeat (8) @(negedge clk);
        check("idle_col2", int'(col), 'hB);
        repeat (8) @(negedge clk);
        check("idle_col3", int'(col), 'h7);
        repeat (8) @(negedge clk);
        check("idle_col0_wrap", int'(col), 'hE);
        check("idle_no_valid", valid_cnt, 0);

        // Clean press r1,c2 -> code 6, then release.
        base = valid_cnt;
        exp_q.push_back(4'h6);
        keys[1*4+2] = 1'b1;
        wait_valid("press_6_valid", 200);
        @(negedge clk);
        check("press_6_code", int'(key_code), 'h6);
        check("press_6_held", int'(key_held), 1);
        repeat (40) @(negedge clk);
        keys[1*4+2] = 1'b0;
        wait_held_low("release_6_held", 60, cyc);
        check("release_6_latency", int'(cyc >= 17 && cyc <= 26), 1);
        check("release_6_col", int'(col), 'h7);
        check("press_6_one_valid", valid_cnt - base, 1);

        // Bouncy press r3,c0: toggles on sample spacing, then settles.
        wait_col("bounce_align", 4'b1110, 40);
        base = valid_cnt;
        for (int i = 0; i < 4; i++) begin
            keys[3*4+0] = ~keys[3*4+0];
            repeat (8) @(negedge clk);
        end
        check("bounce_no_valid", valid_cnt - base, 0);
        exp_q.push_back(4'h0);
        keys[3*4+0] = 1'b1;
        wait_valid("bounce_valid", 200);
        @(negedge clk);
        check("bounce_code", int'(key_code), 'h0);
        keys[3*4+0] = 1'b0;
        wait_held_low("bounce_release", 80, cyc);

        // Short press r0,c3: only two samples low, then released.
        wait_col("short_align", 4'b0111, 60);
        base = valid_cnt;
        keys[0*4+3] = 1'b1;
        repeat (16) @(negedge clk);
        keys[0*4+3] = 1'b0;
        repeat (10) @(negedge clk);
        check("short_col_advanced", int'(col), 'hE);
        check("short_no_valid", valid_cnt - base, 0);
        check("short_code_kept", int'(key_code), 'h0);
        check("short_not_held", int'(key_held), 0);

        // Ghost: two rows low on columns 0 and 1 -> ignored.
        base = valid_cnt;
        ghost = 1'b1;
        repeat (100) @(negedge clk);
        check("ghost_no_valid", valid_cnt - base, 0);
        check("ghost_not_held", int'(key_held), 0);
        ghost = 1'b0;

        // Single key r2,c1 held long -> code 8, one pulse only.
        exp_q.push_back(4'h8);
        keys[2*4+1] = 1'b1;
        wait_valid("press_8_valid", 200);
        repeat (1000) @(negedge clk);
        check("press_8_one_valid", valid_cnt - base, 1);
        check("press_8_code", int'(key_code), 'h8);
        check("press_8_held", int'(key_held), 1);
        keys[2*4+1] = 1'b0;
        wait_held_low("press_8_release", 80, cyc);

        // Reset while r3,c3 is held in PRESSED, then re-detect.
        exp_q.push_back(4'hD);
        keys[3*4+3] = 1'b1;
        wait_valid("press_D_valid", 200);
        repeat (5) @(negedge clk);
        check("press_D_held", int'(key_held), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_col", int'(col), 'hE);
        check("midrst_code", int'(key_code), 0);
        check("midrst_valid", int'(key_valid), 0);
        check("midrst_held", int'(key_held), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = valid_cnt;
        exp_q.push_back(4'hD);
        wait_valid("redetect_D_valid", 200);
        @(negedge clk);
        check("redetect_D_code", int'(key_code), 'hD);
        keys[3*4+3] = 1'b0;
        wait_held_low("redetect_D_release", 80, cyc);
        check("redetect_one_valid", valid_cnt - base, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        check("total_valids", valid_cnt, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
